// File: rtl/display_pkg.sv
// Shared encodings for the multiplexed display arbiter: active-low digit selects,
// FSM states and the fixed left-to-right scan order.
package display_pkg;

    localparam logic [3:0] SEL_D3  = 4'b0111;
    localparam logic [3:0] SEL_D2  = 4'b1011;
    localparam logic [3:0] SEL_D1  = 4'b1101;
    localparam logic [3:0] SEL_D0  = 4'b1110;
    localparam logic [3:0] SEL_OFF = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

    function automatic logic [3:0] next_sel(input logic [3:0] sel);
        logic [3:0] nxt;
        case (sel)
            SEL_D3:  nxt = SEL_D2;
            SEL_D2:  nxt = SEL_D1;
            SEL_D1:  nxt = SEL_D0;
            default: nxt = SEL_D3;
        endcase
        return nxt;
    endfunction

    // Nibble position of a digit within each 16-bit bank (3 = most significant).
    function automatic logic [1:0] digit_pos(input logic [3:0] sel);
        logic [1:0] pos;
        case (sel)
            SEL_D3:  pos = 2'd3;
            SEL_D2:  pos = 2'd2;
            SEL_D1:  pos = 2'd1;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/display_scan_arbiter_rr_pick.sv
// Round-robin pick: first eligible (req & mask) index strictly after ptr, wrapping.
// Purely combinational; vld is low when nothing is eligible.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          vld
);
    logic [N-1:0] elig;

    assign elig = req & mask;

    always_comb begin
        int j;
        j   = 0;
        win = '0;
        idx = '0;
        vld = 1'b0;
        // Farthest candidate first so the nearest eligible one overwrites it.
        for (int k = N; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (elig[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = IW'(j);
                vld    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/led7.sv
// Hex-to-7-segment decoder, combinational. out[6:0] = {g,f,e,d,c,b,a} active-high,
// out[7] = decimal point driven from 'right'.
module led7 (
    input  logic [3:0] digit,
    input  logic       right,
    output logic [7:0] seg
);
    logic [6:0] s;

    always_comb begin
        s = 7'h00;
        case (digit)
            4'h0: s = 7'h3f;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5b;
            4'h3: s = 7'h4f;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6d;
            4'h6: s = 7'h7d;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7f;
            4'h9: s = 7'h6f;
            4'ha: s = 7'h77;
            4'hb: s = 7'h7c;
            4'hc: s = 7'h39;
            4'hd: s = 7'h5e;
            4'he: s = 7'h79;
            default: s = 7'h71;
        endcase
    end

    assign seg = {right, s};
endmodule

// File: rtl/display_scan_arbiter.sv
// Round-robin owner of a 2-bank 4-digit 7-seg display; per-frame snapshot of the winner.
// Handoff: frame end -> 1 LATCH cycle (digits off) -> new owner's first digit.
module display_scan_arbiter
    import display_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [32*NREQ-1:0]  data,
    input  logic [NREQ-1:0]     dot,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [3:0]          selector,
    output logic [7:0]          out1,
    output logic [7:0]          out2
);
    localparam int         IW       = $clog2(NREQ);
    localparam logic [15:0] DIV_M1  = 16'(SCAN_DIV - 1);
    localparam logic [7:0] HOLD_EFF = (HOLD_FRAMES == 0) ? 8'd1 : 8'(HOLD_FRAMES);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [31:0]     snap_q, snap_d;
    logic            dot_q, dot_d;
    logic [3:0]      sel_q, sel_d;
    logic [3:0]      nib1_q, nib1_d;
    logic [3:0]      nib2_q, nib2_d;
    logic [15:0]     presc_q, presc_d;
    logic [7:0]      frames_q, frames_d;

    logic [31:0]     req_dat [NREQ];
    logic [31:0]     owner_dat;
    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [7:0]      frames_inc;
    logic            owner_req;
    logic            others_pend;
    logic [3:0]      nsel;
    logic [1:0]      npos;

    for (genvar g = 0; g < NREQ; g++) begin : g_dat
        assign req_dat[g] = data[32*g +: 32];
    end

    // While a frame is shown the pointer equals the owner's index.
    assign owner_dat   = req_dat[ptr_q];
    assign owner_req   = |(req & grant_q);
    assign others_pend = |(req & ~grant_q);
    assign frames_inc  = (frames_q == 8'hff) ? frames_q : frames_q + 8'd1;
    assign nsel        = next_sel(sel_q);
    assign npos        = digit_pos(nsel);

    // Masking the owner is a no-op in IDLE (grant is zero there).
    rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .mask (~grant_q),
        .win  (pick_win),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        snap_d   = snap_q;
        dot_d    = dot_q;
        sel_d    = sel_q;
        nib1_d   = nib1_q;
        nib2_d   = nib2_q;
        presc_d  = presc_q;
        frames_d = frames_q;
        unique case (state_q)
            ST_IDLE: begin
                sel_d = SEL_OFF;
                if (pick_vld) begin
                    grant_d = pick_win;
                    ptr_d   = pick_idx;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                snap_d   = owner_dat;
                dot_d    = dot[ptr_q];
                frames_d = 8'd0;
                presc_d  = DIV_M1;
                sel_d    = SEL_D3;
                nib1_d   = owner_dat[31:28];
                nib2_d   = owner_dat[15:12];
                state_d  = ST_SCAN;
            end
            ST_SCAN: begin
                if (presc_q != 16'd0) begin
                    presc_d = presc_q - 16'd1;
                end else begin
                    presc_d = DIV_M1;
                    if (sel_q != SEL_D0) begin
                        sel_d  = nsel;
                        nib1_d = snap_q[{1'b1, npos, 2'b00} +: 4];
                        nib2_d = snap_q[{1'b0, npos, 2'b00} +: 4];
                    end else begin
                        frames_d = frames_inc;
                        if (others_pend && (!owner_req || frames_inc >= HOLD_EFF)) begin
                            grant_d = pick_win;
                            ptr_d   = pick_idx;
                            sel_d   = SEL_OFF;
                            state_d = ST_LATCH;
                        end else if (!owner_req) begin
                            grant_d = '0;
                            sel_d   = SEL_OFF;
                            state_d = ST_IDLE;
                        end else begin
                            snap_d = owner_dat;
                            dot_d  = dot[ptr_q];
                            sel_d  = SEL_D3;
                            nib1_d = owner_dat[31:28];
                            nib2_d = owner_dat[15:12];
                        end
                    end
                end
            end
            default: begin
                grant_d = '0;
                sel_d   = SEL_OFF;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= IW'(NREQ - 1);
            snap_q   <= '0;
            dot_q    <= 1'b0;
            sel_q    <= SEL_OFF;
            nib1_q   <= '0;
            nib2_q   <= '0;
            presc_q  <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            snap_q   <= snap_d;
            dot_q    <= dot_d;
            sel_q    <= sel_d;
            nib1_q   <= nib1_d;
            nib2_q   <= nib2_d;
            presc_q  <= presc_d;
            frames_q <= frames_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign selector = sel_q;

    led7 u_led7_bank1 (.digit(nib1_q), .right(dot_q), .seg(out1));
    led7 u_led7_bank2 (.digit(nib2_q), .right(dot_q), .seg(out2));
endmodule

// File: tb/tb_display_scan_arbiter.sv
// Bench for display_scan_arbiter: scoreboard of expected digits on a slow instance
// plus a cycle-by-cycle vector table on a SCAN_DIV=1 / HOLD_FRAMES=0 instance.
module tb_display_scan_arbiter;
    localparam int DIV = 4;

    logic        clock;
    logic        reset;
    logic [1:0]  req,   req_b;
    logic [63:0] data,  data_b;
    logic [1:0]  dot,   dot_b;
    logic [1:0]  grant, grant_b;
    logic        busy,  busy_b;
    logic [3:0]  selector, sel_b;
    logic [7:0]  out1, out2, o1_b, o2_b;

    int checks   = 0;
    int failures = 0;

    display_scan_arbiter #(.NREQ(2), .SCAN_DIV(DIV), .HOLD_FRAMES(2)) u_dut (
        .clock(clock), .reset(reset), .req(req), .data(data), .dot(dot),
        .grant(grant), .busy(busy), .selector(selector), .out1(out1), .out2(out2)
    );

    display_scan_arbiter #(.NREQ(2), .SCAN_DIV(1), .HOLD_FRAMES(0)) u_fast (
        .clock(clock), .reset(reset), .req(req_b), .data(data_b), .dot(dot_b),
        .grant(grant_b), .busy(busy_b), .selector(sel_b), .out1(o1_b), .out2(o2_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [1:0] grant;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [3:0] sel;
        logic [1:0] grant;
        logic [3:0] n1;
        logic [3:0] n2;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [17];

    function automatic logic [7:0] seg(input logic [3:0] n, input logic dp);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3f; 4'h1: s = 7'h06; 4'h2: s = 7'h5b; 4'h3: s = 7'h4f;
            4'h4: s = 7'h66; 4'h5: s = 7'h6d; 4'h6: s = 7'h7d; 4'h7: s = 7'h07;
            4'h8: s = 7'h7f; 4'h9: s = 7'h6f; 4'ha: s = 7'h77; 4'hb: s = 7'h7c;
            4'hc: s = 7'h39; 4'hd: s = 7'h5e; 4'he: s = 7'h79; default: s = 7'h71;
        endcase
        return {dp, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Four scan digits of one frame, in display order.
    task automatic push_frame(input logic [1:0] g, input logic [31:0] d, input logic dp);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.sel   = ~(4'b1000 >> i);
            e.o1    = seg(d[28-4*i +: 4], dp);
            e.o2    = seg(d[12-4*i +: 4], dp);
            e.grant = g;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (sb_q.size() > n && i < budget) begin
            @(posedge clock); #2;
            i++;
        end
        checks++;
        if (sb_q.size() > n) begin
            failures++;
            $display("FAIL %s: timeout, queue=%0d required<=%0d", name, sb_q.size(), n);
        end
    endtask

    task automatic wait_sel(input logic [3:0] val, input int budget, input string name);
        int i;
        i = 0;
        while (selector !== val && i < budget) begin
            @(posedge clock); #2;
            i++;
        end
        check(name, {28'd0, selector}, {28'd0, val});
    endtask

    // Digit monitor: each new digit pops one expectation; every digit must last DIV
    // clocks and the digits-off gap while busy (LATCH) exactly one clock.
    logic       mon_en = 1'b0;
    logic [3:0] mon_prev = 4'hf;
    int         mon_run = 0;
    int         mon_latch = 0;

    always @(negedge clock) begin
        exp_t e;
        if (!mon_en) begin
            mon_prev  = 4'hf;
            mon_run   = 0;
            mon_latch = 0;
        end else begin
            if (selector !== mon_prev) begin
                if (mon_prev != 4'hf) check("digit_len", mon_run, DIV);
                if (selector != 4'hf) begin
                    if (mon_prev == 4'hf) check("latch_len", mon_latch, 1);
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_digit: actual sel=%b required none", selector);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_sel",   {28'd0, selector}, {28'd0, e.sel});
                        check("sb_out1",  {24'd0, out1},     {24'd0, e.o1});
                        check("sb_out2",  {24'd0, out2},     {24'd0, e.o2});
                        check("sb_grant", {30'd0, grant},    {30'd0, e.grant});
                    end
                end
                mon_run   = 1;
                mon_latch = (selector == 4'hf && busy) ? 1 : 0;
            end else begin
                mon_run++;
                if (selector == 4'hf && busy) mon_latch++;
            end
            mon_prev = selector;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req    = 2'b00; data   = '0; dot   = 2'b00;
        req_b  = 2'b00; data_b = '0; dot_b = 2'b00;
        #3 reset = 1'b0;
        #1;
        check("rst_sel",   {28'd0, selector}, 32'hf);
        check("rst_grant", {30'd0, grant},    32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_out1",  {24'd0, out1},     {24'd0, seg(4'h0, 1'b0)});
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #2;

        // Single owner, three frames, req dropped during the third frame's 1011.
        mon_en = 1'b1;
        data[31:0] = 32'h1234_5678;
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        req = 2'b01;
        @(posedge clock); #2;
        check("grant_after_req", {30'd0, grant},    32'd1);
        check("latch_busy",      {31'd0, busy},     32'd1);
        check("latch_sel",       {28'd0, selector}, 32'hf);
        wait_q(2, 100, "wait_f3_d2");
        req = 2'b00;
        wait_q(0, 40, "drain_single");
        wait_sel(4'hf, 20, "release_sel");
        check("release_grant", {30'd0, grant}, 32'd0);
        check("release_busy",  {31'd0, busy},  32'd0);

        // Data change mid-frame shows only from the next frame.
        dot = 2'b01;
        push_frame(2'b01, 32'h1234_5678, 1'b1);
        push_frame(2'b01, 32'hAAAA_BBBB, 1'b1);
        req = 2'b01;
        wait_q(6, 40, "wait_dchg_d2");
        data[31:0] = 32'hAAAA_BBBB;
        wait_q(0, 60, "drain_dchg");
        req = 2'b00;
        wait_sel(4'hf, 20, "dchg_release");

        // Owner drops while the other raises in the same frame.
        dot  = 2'b00;
        data = {32'h4B5A_6978, 32'h0F1E_2D3C};
        push_frame(2'b01, 32'h0F1E_2D3C, 1'b0);
        push_frame(2'b10, 32'h4B5A_6978, 1'b0);
        req = 2'b01;
        wait_q(6, 40, "wait_swap_d2");
        req = 2'b10;
        wait_q(0, 60, "drain_swap");
        req = 2'b00;
        wait_sel(4'hf, 20, "swap_release");

        // Both requesting: two frames each, alternating.
        dot  = 2'b10;
        data = {32'h9ABC_DEF0, 32'h1234_5678};
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        push_frame(2'b10, 32'h9ABC_DEF0, 1'b1);
        push_frame(2'b10, 32'h9ABC_DEF0, 1'b1);
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        push_frame(2'b01, 32'h1234_5678, 1'b0);
        req = 2'b11;
        @(posedge clock); #2;
        check("rr_first", {30'd0, grant}, 32'd1);
        repeat (32) @(posedge clock);
        #2 check("rr_hold_edge33", {30'd0, grant}, 32'd1);
        @(posedge clock); #2;
        check("rr_switch_edge34", {30'd0, grant}, 32'd2);
        wait_q(0, 200, "drain_rr");
        req = 2'b00;
        wait_sel(4'hf, 20, "rr_release");
        check("rr_release_grant", {30'd0, grant}, 32'd0);

        // Asynchronous reset in the middle of a scan.
        mon_en = 1'b0;
        sb_q.delete();
        dot  = 2'b00;
        req  = 2'b01;
        wait_sel(4'b1011, 40, "pre_reset_d2");
        reset = 1'b0;
        #1;
        check("async_rst_sel",   {28'd0, selector}, 32'hf);
        check("async_rst_grant", {30'd0, grant},    32'd0);
        check("async_rst_busy",  {31'd0, busy},     32'd0);
        check("async_rst_out2",  {24'd0, out2},     {24'd0, seg(4'h0, 1'b0)});
        req = 2'b00;
        @(posedge clock); #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #2 check("post_rst_idle", {28'd0, selector}, 32'hf);

        // Fast instance: one clock per digit, owner switches every frame.
        data_b = {32'h2468_ACE0, 32'hC0DE_1357};
        vecs[0]  = '{2'b11, 4'b1111, 2'b01, 4'h0, 4'h0};
        vecs[1]  = '{2'b11, 4'b0111, 2'b01, 4'hC, 4'h1};
        vecs[2]  = '{2'b11, 4'b1011, 2'b01, 4'h0, 4'h3};
        vecs[3]  = '{2'b11, 4'b1101, 2'b01, 4'hD, 4'h5};
        vecs[4]  = '{2'b11, 4'b1110, 2'b01, 4'hE, 4'h7};
        vecs[5]  = '{2'b11, 4'b1111, 2'b10, 4'h0, 4'h0};
        vecs[6]  = '{2'b11, 4'b0111, 2'b10, 4'h2, 4'hA};
        vecs[7]  = '{2'b11, 4'b1011, 2'b10, 4'h4, 4'hC};
        vecs[8]  = '{2'b11, 4'b1101, 2'b10, 4'h6, 4'hE};
        vecs[9]  = '{2'b11, 4'b1110, 2'b10, 4'h8, 4'h0};
        vecs[10] = '{2'b11, 4'b1111, 2'b01, 4'h0, 4'h0};
        vecs[11] = '{2'b11, 4'b0111, 2'b01, 4'hC, 4'h1};
        vecs[12] = '{2'b00, 4'b1011, 2'b01, 4'h0, 4'h3};
        vecs[13] = '{2'b00, 4'b1101, 2'b01, 4'hD, 4'h5};
        vecs[14] = '{2'b00, 4'b1110, 2'b01, 4'hE, 4'h7};
        vecs[15] = '{2'b00, 4'b1111, 2'b00, 4'h0, 4'h0};
        vecs[16] = '{2'b00, 4'b1111, 2'b00, 4'h0, 4'h0};
        for (int i = 0; i < 17; i++) begin
            req_b = vecs[i].req;
            @(posedge clock); #2;
            check($sformatf("fast_sel[%0d]", i),   {28'd0, sel_b},   {28'd0, vecs[i].sel});
            check($sformatf("fast_grant[%0d]", i), {30'd0, grant_b}, {30'd0, vecs[i].grant});
            if (vecs[i].sel != 4'hf) begin
                check($sformatf("fast_out1[%0d]", i), {24'd0, o1_b}, {24'd0, seg(vecs[i].n1, 1'b0)});
                check($sformatf("fast_out2[%0d]", i), {24'd0, o2_b}, {24'd0, seg(vecs[i].n2, 1'b0)});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
